router_pkt_tx: RTL and testbench

Packet transmitter for the router's input port: the packet-producing end of the header/payload/parity protocol that the router's input register block consumes. It collects a payload from an upstream source into a local buffer, then drives the router's `pkt_valid`/`data_in` with the header byte, the payload bytes and a trailing even-XOR parity byte. It stalls on the router's `busy` and reports completion or rejection. It sits in the testbench/SoC-side stimulus path directly in front of the router top.

---
 rtl/router_pkg.sv | 31 +++
 rtl/router_pkt_buf.sv | 31 +++
 rtl/router_pkt_tx.sv | 196 +++++++++++++++++++
 tb/tb_router_pkt_tx.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
// Module   : router_pkg
// Brief    : Shared types and helpers for the router packet transmitter.
// Revision : 1.0 - initial release
// ============================================================================
package router_pkg;

  localparam int ADDR_W   = 2;
  localparam int LEN_W    = 6;
  localparam int MAX_ADDR = 2;

  typedef enum logic [2:0] {
    TX_IDLE    = 3'd0,
    TX_LOAD    = 3'd1,
    TX_HEADER  = 3'd2,
    TX_PAYLOAD = 3'd3,
    TX_PARITY  = 3'd4,
    TX_DONE    = 3'd5
  } tx_state_t;

  // Header byte layout: length in the upper bits, destination in the lower bits.
  function automatic logic [LEN_W+ADDR_W-1:0] make_header(
    input logic [LEN_W-1:0]  len,
    input logic [ADDR_W-1:0] addr
  );
    return {len, addr};
  endfunction

endpackage
`default_nettype wire

// File: rtl/router_pkt_buf.sv
`default_nettype none
// ============================================================================
// Module   : router_pkt_buf
// Brief    : Payload buffer, one write port and one asynchronous read port.
// Revision : 1.0 - initial release
// ============================================================================
module router_pkt_buf #(
  parameter int DEPTH_W = router_pkg::LEN_W,
  parameter int DATA_W  = 8
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [DEPTH_W-1:0] wr_idx,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic [DEPTH_W-1:0] rd_idx,
  output logic [DATA_W-1:0]  rd_data
);

  logic [DATA_W-1:0] r_mem [0:(1<<DEPTH_W)-1];

  // Contents are don't-care until written, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = r_mem[rd_idx];

endmodule
`default_nettype wire

// File: rtl/router_pkt_tx.sv
`default_nettype none
// ============================================================================
// Module   : router_pkt_tx
// Brief    : Buffers a payload, then sends header/payload/parity to the router
//            input port, stalling on busy. Optional ROUTER_PKT_TX_ERRINJ_EN
//            adds err_inj to invert the transmitted parity byte.
// Revision : 1.0 - initial release
// ============================================================================
module router_pkt_tx #(
  parameter int ADDR_W = router_pkg::ADDR_W,
  parameter int LEN_W  = router_pkg::LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] dest_addr,
  input  logic [LEN_W-1:0]  pay_len,
  input  logic [7:0]        pay_data,
  input  logic              pay_valid,
  output logic              pay_ready,
  input  logic              busy,
`ifdef ROUTER_PKT_TX_ERRINJ_EN
  input  logic              err_inj,
`endif
  output logic              pkt_valid,
  output logic [7:0]        data_out,
  output logic              tx_active,
  output logic              done,
  output logic              err
);

  import router_pkg::*;

  localparam logic [LEN_W-1:0] c_CNT_ONE = LEN_W'(1);

  tx_state_t         r_state;
  tx_state_t         w_next;
  logic [LEN_W-1:0]  r_cnt;
  logic [LEN_W-1:0]  w_rd_idx;
  logic [LEN_W-1:0]  w_len;
  logic [LEN_W-1:0]  w_len_m1;
  logic [7:0]        r_header;
  logic [7:0]        r_parity;
  logic [7:0]        r_data_out;
  logic [7:0]        w_rd_data;
  logic [7:0]        w_parity_out;
  logic              r_pkt_valid;
  logic              r_err;
  logic              w_req_bad;
  logic              w_start_ok;
  logic              w_wr_en;
  logic              w_load_last;
  logic              w_pay_last;
  logic              w_consume;
  logic              w_inv;

  assign w_len        = r_header[ADDR_W +: LEN_W];
  assign w_len_m1     = w_len - c_CNT_ONE;
  assign w_req_bad    = (dest_addr > ADDR_W'(MAX_ADDR)) || (pay_len == '0);
  assign w_start_ok   = start && !w_req_bad;
  assign w_wr_en      = (r_state == TX_LOAD) && pay_valid;
  assign w_load_last  = w_wr_en && (r_cnt == w_len_m1);
  assign w_pay_last   = (r_cnt == w_len_m1);
  assign w_consume    = !busy && (r_state inside {TX_HEADER, TX_PAYLOAD, TX_PARITY});
  // In PAYLOAD the byte on data_out is buf[cnt]; prefetch the one after it.
  assign w_rd_idx     = (r_state == TX_PAYLOAD) ? (r_cnt + c_CNT_ONE) : r_cnt;
  assign w_parity_out = r_parity ^ r_data_out ^ {8{w_inv}};

`ifdef ROUTER_PKT_TX_ERRINJ_EN
  logic r_inv;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_inv <= 1'b0;
    end else if ((r_state == TX_IDLE) && w_start_ok) begin
      r_inv <= err_inj;
    end
  end

  assign w_inv = r_inv;
`else
  assign w_inv = 1'b0;
`endif

  router_pkt_buf #(
    .DEPTH_W (LEN_W),
    .DATA_W  (8)
  ) u_buf (
    .clk     (clk),
    .wr_en   (w_wr_en),
    .wr_idx  (r_cnt),
    .wr_data (pay_data),
    .rd_idx  (w_rd_idx),
    .rd_data (w_rd_data)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= TX_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      TX_IDLE:    if (w_start_ok)               w_next = TX_LOAD;
      TX_LOAD:    if (w_load_last)              w_next = TX_HEADER;
      TX_HEADER:  if (w_consume)                w_next = TX_PAYLOAD;
      TX_PAYLOAD: if (w_consume && w_pay_last)  w_next = TX_PARITY;
      TX_PARITY:  if (w_consume)                w_next = TX_DONE;
      TX_DONE:                                  w_next = TX_IDLE;
      default:                                  w_next = TX_IDLE;
    endcase
  end

  always_comb begin
    pay_ready = 1'b0;
    tx_active = 1'b1;
    done      = 1'b0;
    case (r_state)
      TX_IDLE: tx_active = 1'b0;
      TX_LOAD: pay_ready = 1'b1;
      TX_DONE: done      = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt       <= '0;
      r_header    <= '0;
      r_parity    <= '0;
      r_data_out  <= '0;
      r_pkt_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        TX_IDLE: begin
          if (start) begin
            if (w_req_bad) begin
              r_err <= 1'b1;
            end else begin
              r_header <= make_header(pay_len, dest_addr);
              r_cnt    <= '0;
              r_parity <= '0;
            end
          end
        end
        TX_LOAD: begin
          if (w_wr_en) begin
            if (w_load_last) begin
              r_cnt       <= '0;
              r_data_out  <= r_header;
              r_pkt_valid <= 1'b1;
            end else begin
              r_cnt <= r_cnt + c_CNT_ONE;
            end
          end
        end
        TX_HEADER: begin
          if (w_consume) begin
            r_parity   <= r_parity ^ r_header;
            r_data_out <= w_rd_data;
          end
        end
        TX_PAYLOAD: begin
          if (w_consume) begin
            r_parity <= r_parity ^ r_data_out;
            r_cnt    <= r_cnt + c_CNT_ONE;
            if (w_pay_last) begin
              r_data_out  <= w_parity_out;
              r_pkt_valid <= 1'b0;
            end else begin
              r_data_out <= w_rd_data;
            end
          end
        end
        TX_PARITY: begin
          if (w_consume) begin
            r_data_out <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign data_out  = r_data_out;
  assign pkt_valid = r_pkt_valid;
  assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_router_pkt_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_router_pkt_tx
// Brief    : Scoreboard bench for router_pkt_tx: directed packets push expected
//            bytes/events, a negedge monitor pops and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_router_pkt_tx;

  localparam int K_BYTE = 0;
  localparam int K_DONE = 1;
  localparam int K_ERR  = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
    logic       pv;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] dest_addr;
  logic [5:0] pay_len;
  logic [7:0] pay_data;
  logic       pay_valid;
  logic       pay_ready;
  logic       busy;
  logic       pkt_valid;
  logic [7:0] data_out;
  logic       tx_active;
  logic       done;
  logic       err;
`ifdef ROUTER_PKT_TX_ERRINJ_EN
  logic       err_inj;
`endif

  ev_t        exp_q[$];
  ev_t        e;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] pay_mem [0:63];

  always #5 clk = ~clk;

  router_pkt_tx dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dest_addr (dest_addr),
    .pay_len   (pay_len),
    .pay_data  (pay_data),
    .pay_valid (pay_valid),
    .pay_ready (pay_ready),
    .busy      (busy),
`ifdef ROUTER_PKT_TX_ERRINJ_EN
    .err_inj   (err_inj),
`endif
    .pkt_valid (pkt_valid),
    .data_out  (data_out),
    .tx_active (tx_active),
    .done      (done),
    .err       (err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: output event with empty scoreboard", name);
  endtask

  task automatic push_ev(input int k, input logic [7:0] d, input logic p);
    ev_t x;
    x.kind = k;
    x.data = d;
    x.pv   = p;
    exp_q.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: busy keeps the byte on the bus, so peek; otherwise it is consumed.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (err) begin
        if (exp_q.size() == 0) unexpected("err_pulse");
        else begin
          e = exp_q.pop_front();
          check("err_kind", e.kind, K_ERR);
          check("err_idle_outputs", {pkt_valid, tx_active}, 0);
        end
      end
      if (done) begin
        if (exp_q.size() == 0) unexpected("done_pulse");
        else begin
          e = exp_q.pop_front();
          check("done_kind", e.kind, K_DONE);
        end
      end
      if (tx_active && !pay_ready && !done) begin
        if (exp_q.size() == 0) unexpected("tx_byte");
        else begin
          e = busy ? exp_q[0] : exp_q.pop_front();
          check("byte_kind", e.kind, K_BYTE);
          check(busy ? "byte_hold_data" : "byte_data", data_out, e.data);
          check(busy ? "byte_hold_pkt_valid" : "byte_pkt_valid", pkt_valid, e.pv);
        end
      end
    end
  end

  task automatic run_pkt(input logic [1:0] addr, input logic [5:0] len, input logic inj,
                         input bit gapped, input int stall_idx, input int rst_idx);
    logic [7:0] hdr;
    logic [7:0] par;
    int         c;
    hdr = {len, addr};
    par = hdr;
    push_ev(K_BYTE, hdr, 1'b1);
    for (int i = 0; i < len; i++) begin
      par ^= pay_mem[i];
      push_ev(K_BYTE, pay_mem[i], 1'b1);
    end
    if (inj) par = ~par;
    push_ev(K_BYTE, par, 1'b0);
    push_ev(K_DONE, 8'h00, 1'b0);

    start     = 1'b1;
    dest_addr = addr;
    pay_len   = len;
`ifdef ROUTER_PKT_TX_ERRINJ_EN
    err_inj   = inj;
`endif
    tick();
    start = 1'b0;
    check("pay_ready_after_start", {pay_ready, tx_active}, 2'b11);

    for (int i = 0; i < len; i++) begin
      if (gapped && i > 0) begin
        // Gap cycle: also a start and busy that LOAD must ignore.
        pay_valid = 1'b0;
        start     = 1'b1;
        dest_addr = 2'd3;
        busy      = 1'b1;
        tick();
        start = 1'b0;
        busy  = 1'b0;
      end
      pay_valid = 1'b1;
      pay_data  = pay_mem[i];
      tick();
    end
    pay_valid = 1'b0;
    check("header_after_last_write", {tx_active, pay_ready, pkt_valid, data_out},
          {1'b1, 1'b0, 1'b1, hdr});

    if (stall_idx >= 0) begin
      repeat (stall_idx + 1) tick();
      busy = 1'b1;
      repeat (2) tick();
      busy = 1'b0;
    end

    if (rst_idx >= 0) begin
      repeat (rst_idx + 1) tick();
      rst  = 1'b0;
      busy = 1'b1;
      tick();
      check("reset_mid_packet_outputs", {pkt_valid, data_out, pay_ready, tx_active, done, err}, 0);
      rst  = 1'b1;
      busy = 1'b0;
      exp_q.delete();
      repeat (3) tick();
      check("idle_after_reset", {tx_active, done}, 0);
      return;
    end

    c = 0;
    while (tx_active && c < 200) begin
      tick();
      c++;
    end
    check("packet_timeout", tx_active, 0);
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b0;
    start     = 1'b0;
    dest_addr = '0;
    pay_len   = '0;
    pay_data  = '0;
    pay_valid = 1'b0;
    busy      = 1'b0;
`ifdef ROUTER_PKT_TX_ERRINJ_EN
    err_inj   = 1'b0;
`endif
    repeat (2) tick();
    check("reset_outputs", {pkt_valid, data_out, pay_ready, tx_active, done, err}, 0);
    rst = 1'b1;
    tick();

    // Basic packet: header 0x0D, payload 11 22 33, parity 0x0D.
    pay_mem[0] = 8'h11; pay_mem[1] = 8'h22; pay_mem[2] = 8'h33;
    run_pkt(2'd1, 6'd3, 1'b0, 1'b0, -1, -1);

    // Busy for two cycles while 0x22 is on the bus.
    run_pkt(2'd1, 6'd3, 1'b0, 1'b0, 1, -1);

    // Another destination and length: header 0x16.
    pay_mem[0] = 8'hA5; pay_mem[1] = 8'h5A; pay_mem[2] = 8'hFF;
    pay_mem[3] = 8'h00; pay_mem[4] = 8'h3C;
    run_pkt(2'd2, 6'd5, 1'b0, 1'b0, -1, -1);

    // Rejected requests: bad address, then zero length.
    push_ev(K_ERR, 8'h00, 1'b0);
    push_ev(K_ERR, 8'h00, 1'b0);
    start     = 1'b1;
    dest_addr = 2'd3;
    pay_len   = 6'd3;
    tick();
    dest_addr = 2'd0;
    pay_len   = 6'd0;
    tick();
    start = 1'b0;
    repeat (3) tick();
    check("err_events_seen", exp_q.size(), 0);
    check("idle_after_reject", {tx_active, pkt_valid}, 0);

    // Gapped load of 4 bytes, header 0x10.
    pay_mem[0] = 8'h01; pay_mem[1] = 8'h02; pay_mem[2] = 8'h04; pay_mem[3] = 8'h08;
    run_pkt(2'd0, 6'd4, 1'b0, 1'b1, -1, -1);

    // Reset while the second payload byte is driven, then a clean packet.
    pay_mem[0] = 8'h11; pay_mem[1] = 8'h22; pay_mem[2] = 8'h33;
    run_pkt(2'd1, 6'd3, 1'b0, 1'b0, -1, 1);
    run_pkt(2'd1, 6'd3, 1'b0, 1'b0, -1, -1);

    // Maximum length packet.
    for (int i = 0; i < 63; i++) pay_mem[i] = 8'(i * 7 + 3);
    run_pkt(2'd2, 6'd63, 1'b0, 1'b0, -1, -1);

`ifdef ROUTER_PKT_TX_ERRINJ_EN
    // Inverted parity: expected parity byte 0xF2.
    pay_mem[0] = 8'h11; pay_mem[1] = 8'h22; pay_mem[2] = 8'h33;
    run_pkt(2'd1, 6'd3, 1'b1, 1'b0, -1, -1);
    err_inj = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
